// File: rtl/iir_pkg.sv
// Shared types and helpers for the sequential IIR MAC.
// Optional build macro IIR_SAT_EN selects output saturation.
package iir_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_MAC,
    S_WRITE,
    S_DONE
  } iir_state_t;

  localparam int A_BASE = 0;

  localparam logic [1:0] SAT_NONE = 2'd0;
  localparam logic [1:0] SAT_HI   = 2'd1;
  localparam logic [1:0] SAT_LO   = 2'd2;

  function automatic int b_base(input int order);
    return order + 1;
  endfunction

  function automatic int acc_w(
    input int dw,
    input int cw,
    input int order
  );
    return dw + cw + $clog2(2 * order + 1);
  endfunction

  // Classifies v against the signed range of a w-bit word.
  function automatic logic [1:0] sat_sel(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return SAT_HI;
    if (v < lo) return SAT_LO;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/iir_coef_rf.sv
// Coefficient register file: a_0..a_ORDER then b_1..b_ORDER.
// One write port, one combinational read port.
module iir_coef_rf #(
  parameter int NCOEF  = 9,
  parameter int COEF_W = 20,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [COEF_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [COEF_W-1:0] rdata
);

  logic [COEF_W-1:0] mem [NCOEF];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOEF; i++) mem[i] <= '0;
    end else if (we && (int'(waddr) < NCOEF)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < NCOEF) ? mem[raddr] : '0;

endmodule

// File: rtl/iir_seq_mac.sv
// Time-multiplexed IIR filter, one MAC per coefficient per sample.
// Build macro IIR_SAT_EN: clamp results instead of wrapping.
module iir_seq_mac
  import iir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 20,
  parameter int FRAC_W = 16,
  parameter int ORDER  = 4,
  parameter int ADDR_W = 20
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_W-1:0]               DIn,
  input  logic                            data_done,
  input  logic                            coef_we,
  input  logic [$clog2(2*ORDER+1)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]               coef_data,
  output logic                            load,
  output logic [ADDR_W-1:0]               RAddr,
  output logic                            WEN,
  output logic [ADDR_W-1:0]               WAddr,
  output logic [DATA_W-1:0]               Yn,
  output logic                            Finish
);

  localparam int NCOEF  = 2 * ORDER + 1;
  localparam int IDX_W  = $clog2(NCOEF);
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, ORDER);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int B0     = b_base(ORDER);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCOEF - 1);

  iir_state_t state;
  iir_state_t nxt;

  logic [IDX_W-1:0]         idx;
  logic signed [DATA_W-1:0] hist [NCOEF];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [COEF_W-1:0] coef;
  logic signed [PROD_W-1:0] prod;
  logic [DATA_W-1:0]        res;

  iir_coef_rf #(
    .NCOEF  (NCOEF),
    .COEF_W (COEF_W),
    .IDX_W  (IDX_W)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (coef_we),
    .waddr (coef_addr),
    .wdata (coef_data),
    .raddr (idx),
    .rdata (coef)
  );

  // hist[0..ORDER] is x[n-k], hist[ORDER+j] is y[n-j]; one mux feeds the MAC.
  assign prod = PROD_W'(coef) * PROD_W'(hist[idx]);

  assign acc_nxt = (idx < IDX_W'(B0)) ?
                   acc + ACC_W'(prod) :
                   acc - ACC_W'(prod);

`ifdef IIR_SAT_EN
  logic signed [63:0] wide;
  logic [1:0]         sat;

  assign wide = 64'(acc >>> FRAC_W);
  assign sat  = sat_sel(wide, DATA_W);

  always_comb begin
    res = acc[FRAC_W +: DATA_W];
    if (sat == SAT_HI)
      res = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sat == SAT_LO)
      res = {1'b1, {(DATA_W-1){1'b0}}};
  end
`else
  assign res = acc[FRAC_W +: DATA_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  nxt = S_READ;
      S_READ:  nxt = S_WAIT;
      S_WAIT:  nxt = S_MAC;
      S_MAC:   if (idx == LAST) nxt = S_WRITE;
      S_WRITE: nxt = data_done ? S_DONE : S_READ;
      S_DONE:  nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  assign load = (state == S_READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCOEF; k++) hist[k] <= '0;
      acc    <= '0;
      idx    <= '0;
      RAddr  <= '0;
      WAddr  <= '0;
      Yn     <= '0;
      WEN    <= 1'b0;
      Finish <= 1'b0;
    end else begin
      WEN <= 1'b0;
      unique case (state)
        S_WAIT: begin
          hist[0] <= DIn;
          for (int k = 1; k <= ORDER; k++) hist[k] <= hist[k-1];
          acc <= '0;
          idx <= '0;
        end
        S_MAC: begin
          acc <= acc_nxt;
          idx <= idx + 1'b1;
        end
        S_WRITE: begin
          Yn       <= res;
          WEN      <= 1'b1;
          WAddr    <= RAddr;
          RAddr    <= RAddr + 1'b1;
          hist[B0] <= res;
          for (int j = B0 + 1; j < NCOEF; j++) hist[j] <= hist[j-1];
          if (data_done) Finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_seq_mac.sv
// Scoreboard bench for iir_seq_mac; reference model predicts each Yn.
module tb_iir_seq_mac;

  localparam int ORDER = 4;
  localparam int NC    = 2 * ORDER + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] DIn = '0;
  logic        data_done = 1'b0;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [19:0] coef_data = '0;
  logic        load;
  logic [19:0] RAddr;
  logic        WEN;
  logic [19:0] WAddr;
  logic [15:0] Yn;
  logic        Finish;

  iir_seq_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .DIn       (DIn),
    .data_done (data_done),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .load      (load),
    .RAddr     (RAddr),
    .WEN       (WEN),
    .WAddr     (WAddr),
    .Yn        (Yn),
    .Finish    (Finish)
  );

  typedef struct { int idx; int val; int at; } cw_t;
  typedef struct { logic [19:0] a; logic [15:0] y; } exp_t;

  cw_t         cq [$];
  exp_t        eq [$];
  logic [15:0] smem [16];
  longint      mx [ORDER+1];
  longint      my [ORDER+1];
  longint      mc [NC];
  int          stop_at = -1;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_wen = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    return (v << (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint model_step(input logic [15:0] x);
    longint acc;
    for (int k = ORDER; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = sx(longint'(x), 16);
    acc = 0;
    for (int k = 0; k <= ORDER; k++) acc += mc[k] * mx[k];
    for (int j = 1; j <= ORDER; j++) acc -= mc[ORDER+j] * my[j];
    acc = acc >>> 16;
`ifdef IIR_SAT_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`else
    acc = sx(acc, 16);
`endif
    for (int j = ORDER; j > 1; j--) my[j] = my[j-1];
    my[1] = acc;
    return acc;
  endfunction

  // Sample memory, coefficient writer and scoreboard producer.
  always @(negedge clk) begin
    cw_t    w;
    longint y;
    if (rst_n) begin
      coef_we = 1'b0;
      if (cq.size() > 0 &&
          (cq[0].at < 0 || (load && int'(RAddr) == cq[0].at))) begin
        w = cq.pop_front();
        coef_we   = 1'b1;
        coef_addr = 4'(w.idx);
        coef_data = 20'(w.val);
        mc[w.idx] = sx(longint'(w.val), 20);
      end
      if (load) begin
        DIn = smem[RAddr[3:0]];
        data_done = (int'(RAddr) == stop_at);
        y = model_step(DIn);
        eq.push_back('{RAddr, 16'(y)});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_wen = -1;
    end else if (WEN) begin
      if (eq.size() == 0) begin
        chk("extra_wen", 64'(WEN), 64'd0);
      end else begin
        e = eq.pop_front();
        chk("waddr", 64'(WAddr), 64'(e.a));
        chk("yn", 64'(Yn), 64'(e.y));
      end
      if (last_wen >= 0) chk("wen_gap", 64'(cyc - last_wen), 64'd12);
      last_wen = cyc;
    end
  end

  task automatic clear_model();
    for (int k = 0; k <= ORDER; k++) begin
      mx[k] = 0;
      my[k] = 0;
    end
    for (int k = 0; k < NC; k++) mc[k] = 0;
    for (int k = 0; k < 16; k++) smem[k] = '0;
    eq.delete();
    cq.delete();
    DIn = '0;
    data_done = 1'b0;
    coef_we = 1'b0;
    stop_at = -1;
  endtask

  task automatic rst_on();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clear_model();
  endtask

  task automatic rst_off();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_fin(input string tag);
    int n;
    n = 0;
    while (!Finish && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(Finish), 64'd1);
    @(negedge clk);
    chk({tag, "_q"}, 64'(eq.size()), 64'd0);
  endtask

  task automatic setup_pass();
    smem[0] = 16'h1234;
    smem[1] = 16'hFEDC;
    smem[2] = 16'h0000;
    stop_at = 2;
    cq.push_back('{0, 'h10000, -1});
  endtask

  initial begin
    logic seen;
    int   n;
    clear_model();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_load", 64'(load), 64'd0);
    chk("rst_wen", 64'(WEN), 64'd0);
    chk("rst_yn", 64'(Yn), 64'd0);
    chk("rst_raddr", 64'(RAddr), 64'd0);
    chk("rst_waddr", 64'(WAddr), 64'd0);
    chk("rst_fin", 64'(Finish), 64'd0);

    setup_pass();
    rst_off();
    wait_fin("pass_fin");
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | load | WEN;
    end
    chk("term_quiet", 64'(seen), 64'd0);
    chk("term_raddr", 64'(RAddr), 64'd3);
    chk("term_hold", 64'(Finish), 64'd1);

    rst_on();
    smem[0] = 16'h4000;
    stop_at = 3;
    cq.push_back('{0, 'h10000, -1});
    cq.push_back('{ORDER + 1, 'hF8000, -1});
    rst_off();
    wait_fin("decay_fin");

    rst_on();
    smem[0] = 16'h6000;
    smem[1] = 16'h9000;
    stop_at = 1;
    cq.push_back('{0, 'h20000, -1});
    rst_off();
    wait_fin("sat_fin");

    rst_on();
    setup_pass();
    stop_at = -1;
    for (int k = 3; k < 16; k++) smem[k] = 16'(k * 16'h0111);
    rst_off();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(load && RAddr == 20'd5) && n < 500);
    chk("mid_reach", 64'(load && RAddr == 20'd5), 64'd1);
    repeat (4) @(negedge clk);
    chk("mid_pend", 64'(eq.size()), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_load", 64'(load), 64'd0);
    chk("mid_wen", 64'(WEN), 64'd0);
    chk("mid_yn", 64'(Yn), 64'd0);
    chk("mid_raddr", 64'(RAddr), 64'd0);
    chk("mid_waddr", 64'(WAddr), 64'd0);
    chk("mid_fin", 64'(Finish), 64'd0);
    rst_on();
    setup_pass();
    rst_off();
    wait_fin("rerun_fin");

    rst_on();
    smem[0] = 16'h1234;
    smem[1] = 16'h2000;
    smem[2] = 16'h3000;
    stop_at = 2;
    cq.push_back('{0, 'h10000, 1});
    cq.push_back('{0, 'h08000, 2});
    rst_off();
    wait_fin("rdbk_fin");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
